// File: rtl/ariane_pkg.sv
// ariane_pkg: shared branch-resolve and fence FSM types for the flush controller.
package ariane_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] target_address;
        logic        is_mispredict;
        logic        is_taken;
    } bp_resolve_t;
    typedef enum logic {IDLE, FLUSH_DC} fence_state_e;
endpackage

// File: rtl/fence_watchdog.sv
// fence_watchdog: saturating cycle counter that flags expiry at FenceTimeout-1 (0 disables).
module fence_watchdog #(
    parameter int unsigned FenceTimeout = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CntW = (FenceTimeout > 1) ? $clog2(FenceTimeout) : 1;
    localparam logic [CntW-1:0] Last = CntW'(FenceTimeout - 1);
    logic [CntW-1:0] cnt_q;
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) cnt_q <= '0;
        else if (en_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
    assign expired_o = (FenceTimeout != 0) && en_i && (cnt_q == Last);
endmodule

// File: rtl/flush_controller_wb.sv
// flush_controller_wb: pipeline/cache/TLB/BP flush strobes plus a write-back dcache flush
// handshake with core halt and watchdog timeout.
module flush_controller_wb
    import ariane_pkg::*;
#(
    parameter int unsigned NrBranchPorts = 1,
    parameter bit          WriteBack     = 1'b1,
    parameter int unsigned FenceTimeout  = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  bp_resolve_t resolved_branch_i [NrBranchPorts],
    input  logic        fence_i,
    input  logic        fence_i_i,
    input  logic        sfence_vma_i,
    input  logic        flush_csr_i,
    input  logic        flush_commit_i,
    input  logic        ex_valid_i,
    input  logic        eret_i,
    input  logic        set_debug_pc_i,
    input  logic        halt_csr_i,
    input  logic        flush_dcache_ack_i,
    output logic        set_pc_commit_o,
    output logic        flush_if_o,
    output logic        flush_unissued_instr_o,
    output logic        flush_id_o,
    output logic        flush_ex_o,
    output logic        flush_bp_o,
    output logic        flush_icache_o,
    output logic        flush_tlb_o,
    output logic        flush_dcache_o,
    output logic        halt_o,
    output logic        fence_timeout_o
);
    fence_state_e state_q, state_d;
    logic is_fence_i_q, is_fence_i_d, timeout_q, timeout_d;
    logic clear, expired, icache_fsm, mispredict, unused_bp;
    logic pipe_flush, exc_flush;

    always_comb begin
        mispredict = 1'b0;
        unused_bp  = 1'b0;
        for (int k = 0; k < int'(NrBranchPorts); k++) begin
            mispredict |= resolved_branch_i[k].is_mispredict;
            unused_bp  ^= ^resolved_branch_i[k];
        end
    end

    assign pipe_flush             = fence_i | fence_i_i | sfence_vma_i | flush_csr_i | flush_commit_i;
    assign exc_flush              = ex_valid_i | eret_i | set_debug_pc_i;
    assign set_pc_commit_o        = pipe_flush & ~exc_flush;
    assign flush_if_o             = mispredict | pipe_flush | exc_flush;
    assign flush_unissued_instr_o = mispredict | pipe_flush | exc_flush;
    assign flush_id_o             = pipe_flush | exc_flush;
    assign flush_ex_o             = pipe_flush | exc_flush;
    assign flush_bp_o             = exc_flush;
    assign flush_tlb_o            = sfence_vma_i;
    assign flush_icache_o         = WriteBack ? icache_fsm : fence_i_i;
    assign flush_dcache_o         = (state_q == FLUSH_DC);
    assign halt_o                 = halt_csr_i | (state_q == FLUSH_DC);
    assign fence_timeout_o        = timeout_q;

    // Ack takes precedence over a coincident expiry.
    always_comb begin
        state_d      = state_q;
        is_fence_i_d = is_fence_i_q;
        timeout_d    = 1'b0;
        clear        = 1'b0;
        icache_fsm   = 1'b0;
        case (state_q)
            IDLE: if (WriteBack && (fence_i || fence_i_i)) begin
                state_d      = FLUSH_DC;
                is_fence_i_d = fence_i_i;
                clear        = 1'b1;
            end
            FLUSH_DC: if (flush_dcache_ack_i || expired) begin
                state_d    = IDLE;
                icache_fsm = is_fence_i_q;
                timeout_d  = ~flush_dcache_ack_i;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            is_fence_i_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_fence_i_q <= is_fence_i_d;
            timeout_q    <= timeout_d;
        end
    end

    fence_watchdog #(.FenceTimeout(FenceTimeout)) u_watchdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear),
        .en_i      (state_q == FLUSH_DC),
        .expired_o (expired)
    );
endmodule
